// File: rtl/apb_uart_pkg.sv
// Shared types and constants for the APB UART receive/transmit path.
package apb_uart_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } rx_state_e;

  localparam int unsigned UART_DATA_BITS = 8;

endpackage

// File: rtl/apb_uart_sync.sv
// Generic N-stage synchronizer for asynchronous single-bit inputs.
module apb_uart_sync #(
  parameter int unsigned STAGES    = 2,
  parameter logic        RESET_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst_b,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] ff;

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) ff <= {STAGES{RESET_VAL}};
    else        ff <= {ff[STAGES-2:0], d};
  end

  assign q = ff[STAGES-1];

endmodule

// File: rtl/apb_uart_rx.sv
// UART 8N1 receive deserializer: mid-bit sampling via cycle divider, one-cycle valid/frame-error pulses.
// Optional APB_UART_RX_MAJORITY_EN: 2-of-3 majority sampling over the synchronized line.
module apb_uart_rx
  import apb_uart_pkg::*;
#(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic        clk,
  input  logic        rst_b,
  input  logic        uart_rxd,
  input  logic        cfg_rxen,
  input  logic [15:0] cfg_div,
  output logic        rx_valid,
  output logic [7:0]  rx_data,
  output logic        rx_frame_err
);

  rx_state_e state, state_n;
  logic [15:0] cnt, cnt_n;
  logic [2:0]  bitcnt, bitcnt_n;
  logic [15:0] div_q, div_n;
  logic [UART_DATA_BITS-1:0] shreg, shreg_n;
  logic [7:0]  data_n;
  logic        valid_n, ferr_n;
  logic        rxd_s, rxd_d, fall, sample;
  logic [14:0] half;

  apb_uart_sync #(
    .STAGES   (SYNC_STAGES),
    .RESET_VAL(1'b1)
  ) u_sync (
    .clk  (clk),
    .rst_b(rst_b),
    .d    (uart_rxd),
    .q    (rxd_s)
  );

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) rxd_d <= 1'b1;
    else        rxd_d <= rxd_s;
  end

  assign fall = rxd_d & ~rxd_s;
  assign half = div_q[15:1];

`ifdef APB_UART_RX_MAJORITY_EN
  logic rxd_d2;

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) rxd_d2 <= 1'b1;
    else        rxd_d2 <= rxd_d;
  end

  assign sample = (rxd_s & rxd_d) | (rxd_s & rxd_d2) | (rxd_d & rxd_d2);
`else
  assign sample = rxd_s;
`endif

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      state        <= IDLE;
      cnt          <= '0;
      bitcnt       <= '0;
      div_q        <= '0;
      shreg        <= '0;
      rx_data      <= '0;
      rx_valid     <= 1'b0;
      rx_frame_err <= 1'b0;
    end else begin
      state        <= state_n;
      cnt          <= cnt_n;
      bitcnt       <= bitcnt_n;
      div_q        <= div_n;
      shreg        <= shreg_n;
      rx_data      <= data_n;
      rx_valid     <= valid_n;
      rx_frame_err <= ferr_n;
    end
  end

  always_comb begin
    state_n  = state;
    cnt_n    = cnt;
    bitcnt_n = bitcnt;
    div_n    = div_q;
    shreg_n  = shreg;
    data_n   = rx_data;
    valid_n  = 1'b0;
    ferr_n   = 1'b0;

    // Losing the enable aborts any frame in flight without reporting it.
    if (state != IDLE && !cfg_rxen) begin
      state_n = IDLE;
      cnt_n   = '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (cfg_rxen && fall) begin
            state_n = START;
            cnt_n   = '0;
            div_n   = cfg_div;
          end
        end
        START: begin
          if (cnt == {1'b0, half}) begin
            cnt_n    = '0;
            bitcnt_n = '0;
            state_n  = sample ? IDLE : DATA;
          end else begin
            cnt_n = cnt + 16'd1;
          end
        end
        DATA: begin
          if (cnt == div_q) begin
            shreg_n  = {sample, shreg[UART_DATA_BITS-1:1]};
            cnt_n    = '0;
            bitcnt_n = bitcnt + 3'd1;
            if (bitcnt == 3'(UART_DATA_BITS - 1)) state_n = STOP;
          end else begin
            cnt_n = cnt + 16'd1;
          end
        end
        STOP: begin
          // Leaving at mid-stop lets a back-to-back start bit be caught half a bit later.
          if (cnt == div_q) begin
            if (sample) begin
              data_n  = shreg;
              valid_n = 1'b1;
            end else begin
              ferr_n = 1'b1;
            end
            state_n = IDLE;
            cnt_n   = '0;
          end else begin
            cnt_n = cnt + 16'd1;
          end
        end
        default: state_n = IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_apb_uart_rx.sv
// Directed self-checking bench for apb_uart_rx (8N1 receive, enable/reset/divider boundaries).
module tb_apb_uart_rx;
  import apb_uart_pkg::*;

  logic        clk = 1'b0;
  logic        rst_b = 1'b0;
  logic        uart_rxd = 1'b1;
  logic        cfg_rxen = 1'b0;
  logic [15:0] cfg_div = 16'd15;
  logic        rx_valid;
  logic [7:0]  rx_data;
  logic        rx_frame_err;

  int total = 0;
  int bad = 0;
  int unsigned cyc = 0;
  int unsigned start_cyc = 0;

  logic [7:0]  vq[$];
  int unsigned vtime = 0;
  int unsigned fcnt = 0;
  logic prev_v = 1'b0, prev_f = 1'b0;
  logic overlap = 1'b0, longpulse = 1'b0;

  apb_uart_rx #(.SYNC_STAGES(2)) dut (
    .clk         (clk),
    .rst_b       (rst_b),
    .uart_rxd    (uart_rxd),
    .cfg_rxen    (cfg_rxen),
    .cfg_div     (cfg_div),
    .rx_valid    (rx_valid),
    .rx_data     (rx_data),
    .rx_frame_err(rx_frame_err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (rx_valid) begin
      vq.push_back(rx_data);
      vtime = cyc;
    end
    if (rx_frame_err) fcnt++;
    if (rx_valid && rx_frame_err) overlap = 1'b1;
    if ((rx_valid || rx_frame_err) && (prev_v || prev_f)) longpulse = 1'b1;
    prev_v = rx_valid;
    prev_f = rx_frame_err;
  end

  task automatic idle(input int unsigned n);
    repeat (n) @(negedge clk);
  endtask

  // Drives one 8N1 frame; glitch_idx selects a frame bit inverted for one cycle at offset 8.
  task automatic send_frame(input logic [7:0] d, input logic stop, input int unsigned div,
                            input int glitch_idx);
    logic [9:0] bits;
    bits = {stop, d, 1'b0};
    start_cyc = cyc;
    for (int i = 0; i < 10; i++) begin
      for (int unsigned c = 0; c <= div; c++) begin
        uart_rxd = bits[i] ^ ((i == glitch_idx) && (c == 8));
        @(negedge clk);
      end
    end
    uart_rxd = 1'b1;
  endtask

  task automatic test_reset;
    idle(3);
    total++; if (rx_valid !== 1'b0) begin bad++; $display("FAIL reset_valid: got %b want 0", rx_valid); end
    total++; if (rx_data !== 8'h00) begin bad++; $display("FAIL reset_data: got %h want 00", rx_data); end
    total++; if (rx_frame_err !== 1'b0) begin bad++; $display("FAIL reset_ferr: got %b want 0", rx_frame_err); end
    total++; if (dut.state !== IDLE) begin bad++; $display("FAIL reset_state: got %0d want 0", dut.state); end
    rst_b = 1'b1;
    cfg_rxen = 1'b1;
    idle(5);
  endtask

  task automatic test_basic;
    int unsigned n0, f0;
    n0 = vq.size(); f0 = fcnt;
    cfg_div = 16'd15;
    send_frame(8'hA5, 1'b1, 15, -1);
    idle(20);
    total++; if (vq.size() !== n0 + 1) begin bad++; $display("FAIL basic_count: got %0d want %0d", vq.size(), n0 + 1); end
    total++; if (rx_data !== 8'hA5) begin bad++; $display("FAIL basic_data: got %h want a5", rx_data); end
    total++; if (fcnt !== f0) begin bad++; $display("FAIL basic_ferr: got %0d want %0d", fcnt, f0); end
    total++; if (vtime - start_cyc !== 155) begin bad++; $display("FAIL basic_latency: got %0d want 155", vtime - start_cyc); end
  endtask

  task automatic test_start_glitch;
    int unsigned n0, f0;
    n0 = vq.size(); f0 = fcnt;
    uart_rxd = 1'b0;
    idle(4);
    uart_rxd = 1'b1;
    idle(30);
    total++; if (vq.size() !== n0) begin bad++; $display("FAIL sglitch_valid: got %0d want %0d", vq.size(), n0); end
    total++; if (fcnt !== f0) begin bad++; $display("FAIL sglitch_ferr: got %0d want %0d", fcnt, f0); end
    total++; if (dut.state !== IDLE) begin bad++; $display("FAIL sglitch_state: got %0d want 0", dut.state); end
    send_frame(8'h3C, 1'b1, 15, -1);
    idle(20);
    total++; if (vq.size() !== n0 + 1) begin bad++; $display("FAIL sglitch_next_count: got %0d want %0d", vq.size(), n0 + 1); end
    total++; if (rx_data !== 8'h3C) begin bad++; $display("FAIL sglitch_next_data: got %h want 3c", rx_data); end
  endtask

  task automatic test_frame_err;
    int unsigned n0, f0;
    n0 = vq.size(); f0 = fcnt;
    cfg_div = 16'd7;
    send_frame(8'h81, 1'b0, 7, -1);
    uart_rxd = 1'b0;
    idle(20);
    uart_rxd = 1'b1;
    idle(20);
    total++; if (fcnt !== f0 + 1) begin bad++; $display("FAIL ferr_count: got %0d want %0d", fcnt, f0 + 1); end
    total++; if (vq.size() !== n0) begin bad++; $display("FAIL ferr_valid: got %0d want %0d", vq.size(), n0); end
    total++; if (rx_data !== 8'h3C) begin bad++; $display("FAIL ferr_data_kept: got %h want 3c", rx_data); end
  endtask

  task automatic test_back_to_back;
    int unsigned n0, f0;
    n0 = vq.size(); f0 = fcnt;
    cfg_div = 16'd3;
    send_frame(8'h00, 1'b1, 3, -1);
    send_frame(8'hFF, 1'b1, 3, -1);
    idle(20);
    total++; if (vq.size() !== n0 + 2) begin bad++; $display("FAIL b2b_count: got %0d want %0d", vq.size(), n0 + 2); end
    else begin
      total++; if (vq[n0] !== 8'h00) begin bad++; $display("FAIL b2b_first: got %h want 00", vq[n0]); end
      total++; if (vq[n0+1] !== 8'hFF) begin bad++; $display("FAIL b2b_second: got %h want ff", vq[n0+1]); end
    end
    total++; if (fcnt !== f0) begin bad++; $display("FAIL b2b_ferr: got %0d want %0d", fcnt, f0); end
  endtask

  task automatic test_rxen_off;
    int unsigned n0, f0;
    n0 = vq.size(); f0 = fcnt;
    cfg_div = 16'd15;
    cfg_rxen = 1'b0;
    send_frame(8'h5A, 1'b1, 15, -1);
    idle(20);
    total++; if (vq.size() !== n0) begin bad++; $display("FAIL rxen_off_valid: got %0d want %0d", vq.size(), n0); end
    total++; if (fcnt !== f0) begin bad++; $display("FAIL rxen_off_ferr: got %0d want %0d", fcnt, f0); end
    cfg_rxen = 1'b1;
    idle(5);
  endtask

  task automatic test_rxen_drop;
    int unsigned n0, f0;
    n0 = vq.size(); f0 = fcnt;
    fork
      send_frame(8'h55, 1'b1, 15, -1);
      begin
        idle(60);
        cfg_rxen = 1'b0;
        idle(2);
        total++; if (dut.state !== IDLE) begin bad++; $display("FAIL rxen_drop_state: got %0d want 0", dut.state); end
      end
    join
    idle(20);
    total++; if (vq.size() !== n0) begin bad++; $display("FAIL rxen_drop_valid: got %0d want %0d", vq.size(), n0); end
    total++; if (fcnt !== f0) begin bad++; $display("FAIL rxen_drop_ferr: got %0d want %0d", fcnt, f0); end
    total++; if (rx_data !== 8'hFF) begin bad++; $display("FAIL rxen_drop_data_kept: got %h want ff", rx_data); end
    cfg_rxen = 1'b1;
    idle(5);
  endtask

  task automatic test_div_change;
    int unsigned n0;
    n0 = vq.size();
    cfg_div = 16'd15;
    fork
      send_frame(8'h96, 1'b1, 15, -1);
      begin
        idle(50);
        cfg_div = 16'd7;
      end
    join
    idle(20);
    cfg_div = 16'd15;
    total++; if (vq.size() !== n0 + 1) begin bad++; $display("FAIL divchg_count: got %0d want %0d", vq.size(), n0 + 1); end
    total++; if (rx_data !== 8'h96) begin bad++; $display("FAIL divchg_data: got %h want 96", rx_data); end
  endtask

  task automatic test_reset_mid;
    int unsigned n0, f0;
    n0 = vq.size(); f0 = fcnt;
    fork
      send_frame(8'hF0, 1'b1, 15, -1);
      begin
        idle(100);
        rst_b = 1'b0;
        #1;
        total++; if (rx_valid !== 1'b0) begin bad++; $display("FAIL rstmid_valid: got %b want 0", rx_valid); end
        total++; if (rx_data !== 8'h00) begin bad++; $display("FAIL rstmid_data: got %h want 00", rx_data); end
        total++; if (rx_frame_err !== 1'b0) begin bad++; $display("FAIL rstmid_ferr: got %b want 0", rx_frame_err); end
        total++; if (dut.state !== IDLE) begin bad++; $display("FAIL rstmid_state: got %0d want 0", dut.state); end
        @(negedge clk);
        @(negedge clk);
        rst_b = 1'b1;
      end
    join
    idle(20);
    total++; if (vq.size() !== n0) begin bad++; $display("FAIL rstmid_partial: got %0d want %0d", vq.size(), n0); end
    total++; if (fcnt !== f0) begin bad++; $display("FAIL rstmid_partial_ferr: got %0d want %0d", fcnt, f0); end
    send_frame(8'h5A, 1'b1, 15, -1);
    idle(20);
    total++; if (vq.size() !== n0 + 1) begin bad++; $display("FAIL rstmid_next_count: got %0d want %0d", vq.size(), n0 + 1); end
    total++; if (rx_data !== 8'h5A) begin bad++; $display("FAIL rstmid_next_data: got %h want 5a", rx_data); end
  endtask

  task automatic test_sample_glitch;
    int unsigned n0;
    logic [7:0] exp;
`ifdef APB_UART_RX_MAJORITY_EN
    exp = 8'hFF;
`else
    exp = 8'hF7;
`endif
    n0 = vq.size();
    send_frame(8'hFF, 1'b1, 15, 4);
    idle(20);
    total++; if (vq.size() !== n0 + 1) begin bad++; $display("FAIL dglitch_count: got %0d want %0d", vq.size(), n0 + 1); end
    total++; if (rx_data !== exp) begin bad++; $display("FAIL dglitch_data: got %h want %h", rx_data, exp); end
  endtask

  task automatic test_protocol;
    total++; if (overlap !== 1'b0) begin bad++; $display("FAIL proto_overlap: got %b want 0", overlap); end
    total++; if (longpulse !== 1'b0) begin bad++; $display("FAIL proto_pulse_width: got %b want 0", longpulse); end
  endtask

  initial begin
    @(negedge clk);
    test_reset;
    test_basic;
    test_start_glitch;
    test_frame_err;
    test_back_to_back;
    test_rxen_off;
    test_rxen_drop;
    test_div_change;
    test_reset_mid;
    test_sample_glitch;
    test_protocol;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
